// File: rtl/mem_request.sv
//------------------------------------------------------------------------------
// Module      : mem_request
// Description : EX/MEM pipeline register and data-cache request sequencer.
//               Stores are byte-lane replicated and masked; loads request full words.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_request #(
    parameter int CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_reg_we,
    input  logic        ex_mem_we,
    input  logic        ex_mem_rr,
    input  logic        ex_jump,
    input  logic [4:0]  ex_rd,

    input  logic        stall,
    input  logic        dcache_stall,

    output logic [31:0] dcache_addr,
    output logic [31:0] dcache_din,
    output logic [3:0]  dcache_we,
    output logic        dcache_re,

    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_alu_result,
    output logic [2:0]  wb_funct3,
    output logic        wb_reg_we,
    output logic        wb_mem_we,
    output logic        wb_mem_rr,
    output logic        wb_jump,
    output logic [4:0]  wb_rd,
    output logic        mem_ready,
    output logic        busy,
    output logic        misaligned
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_alu_result;
    logic [31:0] r_rs2;
    logic [2:0]  r_funct3;
    logic        r_reg_we;
    logic        r_mem_we;
    logic        r_mem_rr;
    logic        r_jump;
    logic [4:0]  r_rd;
    logic        r_mis_reported;

    logic        w_hold;
    logic        w_mem_op;
    logic        w_misal_raw;
    logic        w_misal_addr;
    logic        w_misal;
    logic        w_go;
    logic [31:0] w_store_data;
    logic [3:0]  w_mask;

    assign w_hold = stall | busy;

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_alu_result <= '0;
            r_rs2        <= '0;
            r_funct3     <= '0;
            r_reg_we     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_rr     <= 1'b0;
            r_jump       <= 1'b0;
            r_rd         <= '0;
        end else if (!w_hold) begin
            r_valid      <= ex_valid;
            r_pc         <= ex_pc;
            r_alu_result <= ex_alu_result;
            r_rs2        <= ex_rs2;
            r_funct3     <= ex_funct3;
            r_reg_we     <= ex_reg_we;
            r_mem_we     <= ex_mem_we;
            r_mem_rr     <= ex_mem_rr;
            r_jump       <= ex_jump;
            r_rd         <= ex_rd;
        end
    end

    // Keeps the misaligned pulse to one cycle while a downstream stall holds the op
    always_ff @(posedge clk) begin
        if (reset || !w_hold) begin
            r_mis_reported <= 1'b0;
        end else if (w_misal) begin
            r_mis_reported <= 1'b1;
        end
    end

    assign wb_valid      = r_valid;
    assign wb_pc         = r_pc;
    assign wb_alu_result = r_alu_result;
    assign wb_funct3     = r_funct3;
    assign wb_reg_we     = r_reg_we;
    assign wb_mem_we     = r_mem_we;
    assign wb_mem_rr     = r_mem_rr;
    assign wb_jump       = r_jump;
    assign wb_rd         = r_rd;

    assign w_mem_op = r_valid & (r_mem_we | r_mem_rr);

    always_comb begin
        w_misal_raw = 1'b0;
        case (r_funct3[1:0])
            2'b00:   w_misal_raw = 1'b0;
            2'b01:   w_misal_raw = r_alu_result[0];
            default: w_misal_raw = |r_alu_result[1:0];
        endcase
    end

    generate
        if (CHECK_ALIGN != 0) begin : g_align_check
            assign w_misal_addr = w_misal_raw;
        end else begin : g_no_align_check
            assign w_misal_addr = 1'b0;
        end
    endgenerate

    assign w_misal = w_mem_op & w_misal_addr;
    assign w_go    = w_mem_op & ~w_misal_addr;

    // Byte lanes are replicated so the mask alone selects the written bytes
    always_comb begin
        w_store_data = r_rs2;
        w_mask       = 4'b1111;
        case (r_funct3[1:0])
            2'b00: begin
                w_store_data = {4{r_rs2[7:0]}};
                w_mask       = 4'b0001 << r_alu_result[1:0];
            end
            2'b01: begin
                w_store_data = {2{r_rs2[15:0]}};
                w_mask       = 4'b0011 << {r_alu_result[1], 1'b0};
            end
            default: begin
                w_store_data = r_rs2;
                w_mask       = 4'b1111;
            end
        endcase
    end

    assign dcache_addr = {r_alu_result[31:2], 2'b00};
    assign dcache_din  = w_store_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_go)          w_next_state = ST_REQ;
            ST_REQ:  if (!dcache_stall) w_next_state = ST_DONE;
            ST_DONE: if (!stall)        w_next_state = ST_IDLE;
            default:                    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        dcache_re  = 1'b0;
        dcache_we  = 4'b0000;
        mem_ready  = 1'b0;
        busy       = 1'b0;
        misaligned = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy       = w_go;
                mem_ready  = w_misal;
                misaligned = w_misal & ~r_mis_reported;
            end
            ST_REQ: begin
                busy      = 1'b1;
                // A combined read/write request is issued as a store only
                dcache_re = r_mem_rr & ~r_mem_we;
                dcache_we = r_mem_we ? w_mask : 4'b0000;
            end
            ST_DONE: begin
                mem_ready = 1'b1;
                busy      = stall;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_request.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_request
// Description : Directed and randomized bench for mem_request against a
//               transaction-level model of the request sequence.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_request;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [2:0]  f3;
        logic        reg_we;
        logic        mem_we;
        logic        mem_rr;
        logic        jump;
        logic [4:0]  rd;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2;
    logic [2:0]  ex_funct3;
    logic        ex_reg_we;
    logic        ex_mem_we;
    logic        ex_mem_rr;
    logic        ex_jump;
    logic [4:0]  ex_rd;
    logic        stall;
    logic        dcache_stall;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_din;
    logic [3:0]  dcache_we;
    logic        dcache_re;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_alu_result;
    logic [2:0]  wb_funct3;
    logic        wb_reg_we;
    logic        wb_mem_we;
    logic        wb_mem_rr;
    logic        wb_jump;
    logic [4:0]  wb_rd;
    logic        mem_ready;
    logic        busy;
    logic        misaligned;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_request #(.CHECK_ALIGN(1)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
        .ex_rs2(ex_rs2), .ex_funct3(ex_funct3), .ex_reg_we(ex_reg_we),
        .ex_mem_we(ex_mem_we), .ex_mem_rr(ex_mem_rr), .ex_jump(ex_jump),
        .ex_rd(ex_rd), .stall(stall), .dcache_stall(dcache_stall),
        .dcache_addr(dcache_addr), .dcache_din(dcache_din),
        .dcache_we(dcache_we), .dcache_re(dcache_re),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_alu_result(wb_alu_result),
        .wb_funct3(wb_funct3), .wb_reg_we(wb_reg_we), .wb_mem_we(wb_mem_we),
        .wb_mem_rr(wb_mem_rr), .wb_jump(wb_jump), .wb_rd(wb_rd),
        .mem_ready(mem_ready), .busy(busy), .misaligned(misaligned)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_t o);
        ex_valid      = o.valid;
        ex_pc         = o.pc;
        ex_alu_result = o.alu;
        ex_rs2        = o.rs2;
        ex_funct3     = o.f3;
        ex_reg_we     = o.reg_we;
        ex_mem_we     = o.mem_we;
        ex_mem_rr     = o.mem_rr;
        ex_jump       = o.jump;
        ex_rd         = o.rd;
    endtask

    // Reference model: access size from funct3, plain arithmetic for lanes/mask
    function automatic int size_of(input op_t o);
        return 1 << int'(o.f3[1:0]);
    endfunction

    function automatic bit exp_mis(input op_t o);
        int sz = size_of(o);
        return (sz > 1) && ((o.alu % 32'(sz)) != 32'd0);
    endfunction

    function automatic logic [31:0] exp_addr(input op_t o);
        return o.alu - (o.alu % 32'd4);
    endfunction

    function automatic logic [31:0] exp_din(input op_t o);
        logic [31:0] v;
        int sz = size_of(o);
        if (sz == 1) begin
            v = 32'(o.rs2[7:0]);
            return v * 32'h0101_0101;
        end else if (sz == 2) begin
            v = 32'(o.rs2[15:0]);
            return v * 32'h0001_0001;
        end
        return o.rs2;
    endfunction

    function automatic logic [3:0] exp_mask(input op_t o);
        int sz  = size_of(o);
        int ofs = int'(o.alu % 32'd4);
        return 4'(((1 << sz) - 1) << ofs);
    endfunction

    function automatic logic [127:0] wb_of(input op_t o);
        return 128'({o.valid, o.pc, o.alu, o.f3, o.reg_we, o.mem_we, o.mem_rr, o.jump, o.rd});
    endfunction

    function automatic logic [127:0] obs_wb();
        return 128'({wb_valid, wb_pc, wb_alu_result, wb_funct3, wb_reg_we,
                     wb_mem_we, wb_mem_rr, wb_jump, wb_rd});
    endfunction

    function automatic logic [127:0] obs_ctl();
        return 128'({busy, mem_ready, dcache_re, dcache_we, misaligned});
    endfunction

    function automatic logic [127:0] ctl(input bit b, input bit r, input bit re,
                                         input logic [3:0] we, input bit m);
        return 128'({b, r, re, we, m});
    endfunction

    function automatic op_t mk(input logic [2:0] f3, input bit we, input bit rr,
                               input logic [31:0] alu, input logic [31:0] rs2);
        op_t o;
        o.valid  = 1'b1;
        o.pc     = $urandom;
        o.alu    = alu;
        o.rs2    = rs2;
        o.f3     = f3;
        o.reg_we = rr;
        o.mem_we = we;
        o.mem_rr = rr;
        o.jump   = 1'b0;
        o.rd     = 5'($urandom);
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int k;
        int loads [5] = '{0, 1, 2, 4, 5};
        o.valid  = ($urandom % 8) != 0;
        o.pc     = $urandom;
        o.alu    = $urandom;
        o.rs2    = $urandom;
        o.reg_we = 1'($urandom);
        o.jump   = 1'($urandom);
        o.rd     = 5'($urandom);
        k        = int'($urandom % 4);
        o.mem_we = (k == 1) || (k == 3);
        o.mem_rr = (k == 2) || (k == 3);
        if (o.mem_we)      o.f3 = 3'($urandom % 3);
        else if (o.mem_rr) o.f3 = 3'(loads[$urandom % 5]);
        else               o.f3 = 3'($urandom);
        return o;
    endfunction

    // One op: load into the register, then follow the expected IDLE/REQ/DONE path.
    // Leaves the bench in a cycle where the register will reload at the next edge.
    task automatic run_op(input op_t o, input int dst, input int sst);
        bit is_mem;
        bit mis;
        drive(o);
        stall        = 1'b0;
        dcache_stall = 1'($urandom);
        tick();
        drive(rand_op());
        dcache_stall = 1'($urandom);
        #1;
        is_mem = o.valid && (o.mem_we || o.mem_rr);
        mis    = is_mem && exp_mis(o);
        chk("wb_load", obs_wb(), wb_of(o));
        if (!is_mem) begin
            chk("idle_nonmem", obs_ctl(), ctl(0, 0, 0, 4'b0000, 0));
        end else if (mis) begin
            chk("misaligned", obs_ctl(), ctl(0, 1, 0, 4'b0000, 1));
        end else begin
            chk("idle_mem", obs_ctl(), ctl(1, 0, 0, 4'b0000, 0));
            tick();
            for (int i = 0; i <= dst; i++) begin
                dcache_stall = (i < dst);
                stall        = 1'($urandom);
                drive(rand_op());
                #1;
                chk("req_ctl", obs_ctl(),
                    ctl(1, 0, !o.mem_we, o.mem_we ? exp_mask(o) : 4'b0000, 0));
                chk("req_addr", 128'(dcache_addr), 128'(exp_addr(o)));
                if (o.mem_we) chk("req_din", 128'(dcache_din), 128'(exp_din(o)));
                chk("req_hold", obs_wb(), wb_of(o));
                tick();
            end
            for (int j = 0; j <= sst; j++) begin
                stall        = (j < sst);
                dcache_stall = 1'($urandom);
                drive(rand_op());
                #1;
                chk("done_ctl", obs_ctl(), ctl(stall, 1, 0, 4'b0000, 0));
                chk("done_hold", obs_wb(), wb_of(o));
                if (j < sst) tick();
            end
        end
    endtask

    initial begin
        op_t o;
        reset        = 1'b1;
        stall        = 1'b0;
        dcache_stall = 1'b0;
        drive(op_t'(0));
        tick();
        drive(rand_op());
        tick();
        chk("reset_wb", obs_wb(), 128'(0));
        chk("reset_ctl", obs_ctl(), ctl(0, 0, 0, 4'b0000, 0));
        reset = 1'b0;

        run_op(mk(3'b010, 1, 0, 32'h0000_1000, 32'hDEAD_BEEF), 0, 0);
        run_op(mk(3'b000, 1, 0, 32'h0000_2003, 32'h0000_00A5), 0, 0);
        run_op(mk(3'b010, 0, 1, 32'h0000_0040, $urandom), 3, 0);
        run_op(mk(3'b001, 0, 1, 32'h0000_0041, $urandom), 0, 0);
        run_op(mk(3'b001, 1, 1, 32'h0000_0102, 32'h1234_5678), 1, 2);
        run_op(mk(3'b010, 1, 0, 32'h0000_0042, $urandom), 0, 0);

        // Reset while a load is waiting on the cache
        o = mk(3'b010, 0, 1, 32'h0000_0080, $urandom);
        drive(o);
        stall = 1'b0;
        tick();
        drive(rand_op());
        tick();
        dcache_stall = 1'b1;
        #1;
        chk("pre_reset_re", 128'(dcache_re), 128'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset", 128'({dcache_re, dcache_we, busy, mem_ready, wb_valid}), 128'(0));

        for (int n = 0; n < 200; n++) begin
            run_op(rand_op(), int'($urandom % 4), int'($urandom % 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/mem_request.md
MEM_REQUEST -- requirements
Module: mem_request

Interface
REQ-001 SHALL have parameter CHECK_ALIGN, default 1, meaning 1 = detect misaligned half/word accesses and suppress them.
REQ-002 SHALL have ports, clock and reset first: clk in 1, clock; reset in 1, reset, synchronous, active-high.
REQ-003 SHALL have inputs from execute: ex_valid 1; ex_pc 32; ex_alu_result 32 (address/result); ex_rs2 32 (store data); ex_funct3 3; ex_reg_we 1; ex_mem_we 1; ex_mem_rr 1; ex_jump 1; ex_rd 5.
REQ-004 SHALL have stall in 1, the downstream freeze.
REQ-005 SHALL have dcache_stall in 1, meaning the cache cannot accept or complete a request.
REQ-006 SHALL have outputs to dcache: dcache_addr out 32 (word-aligned); dcache_din out 32; dcache_we out 4 (byte mask); dcache_re out 1.
REQ-007 SHALL have outputs to writeback: wb_valid, wb_pc, wb_alu_result, wb_funct3, wb_reg_we, wb_mem_we, wb_mem_rr, wb_jump, wb_rd (widths as ex_*); mem_ready out 1 (memory op finished); busy out 1 (freeze upstream); misaligned out 1 (one-cycle pulse).

Function
REQ-008 SHALL hold one EX/MEM pipeline register; hold = stall | busy; when hold is low, the register loads all ex_* at the clock edge; when hold is high, it retains its contents.
REQ-009 SHALL drive wb_* directly from the register; wb_valid = registered ex_valid.
REQ-010 SHALL implement FSM states IDLE, REQ, DONE.
REQ-011 IDLE: if the register holds valid & (mem_we | mem_rr) and the access is aligned, SHALL assert busy and go to REQ on the next edge; a non-memory op SHALL stay in IDLE with mem_ready=0 and busy=0.
REQ-012 REQ: SHALL drive dcache_re = mem_rr and dcache_we = byte mask if mem_we, else 0; dcache_addr = {alu_result[31:2],2'b00}; busy=1; stays in REQ while dcache_stall=1; goes to DONE at the first edge with dcache_stall=0.
REQ-013 DONE: SHALL deassert dcache_re/dcache_we, assert mem_ready=1 and busy=stall; go to IDLE at the first edge with stall=0.
REQ-014 Store data SHALL be: sb {4{rs2[7:0]}}, mask 4'b0001<<addr[1:0]; sh {2{rs2[15:0]}}, mask 4'b0011<<{addr[1],1'b0}; sw rs2, mask 4'b1111.
REQ-015 Loads (funct3 000,001,010,100,101) SHALL use dcache_we=0 and dcache_re=1; byte extraction is not done here.
REQ-016 With CHECK_ALIGN=1, half access with addr[0]=1, or word access with addr[1:0]!=0, SHALL issue no request, pulse misaligned for one cycle, pass through to writeback with mem_ready=1, and never enter REQ.
REQ-017 mem_we and mem_rr both set SHALL be treated as a store only.
REQ-018 The dcache address, data and mask SHALL stay stable throughout REQ.
REQ-019 Back-to-back memory ops SHALL each pass IDLE->REQ->DONE; no request SHALL be issued in the DONE cycle.
REQ-020 dcache_stall SHALL be ignored outside REQ.
REQ-021 A stall asserted during REQ SHALL not abort the request; the FSM SHALL complete and wait in DONE.

Reset
REQ-022 On reset, state SHALL be IDLE, all wb_* SHALL be 0, and dcache_re=0, dcache_we=0, mem_ready=0, busy=0, misaligned=0.
REQ-023 Reset in REQ or DONE SHALL abort the op, with dcache_re/dcache_we low on the next cycle and no completion reported.

Verification
REQ-024 sw, addr 0x1000, rs2 0xDEADBEEF, dcache_stall 0 -> one REQ cycle with addr 0x1000, din 0xDEADBEEF, we 4'b1111; then mem_ready=1.
REQ-025 sb, addr 0x2003, rs2 0x000000A5 -> dcache_addr 0x2000, din 0xA5A5A5A5, we 4'b1000.
REQ-026 lw, addr 0x40, dcache_stall high 3 cycles -> re=1 held 4 cycles, busy=1 throughout, ex_* changes not captured, mem_ready=1 after.
REQ-027 lh, addr 0x41 -> misaligned pulse, re=0 and we=0, no REQ state.
REQ-028 Reset mid-REQ with dcache_stall=1 -> next cycle re=0, we=0, busy=0, wb_valid=0.
REQ-029 stall=1 during DONE for 2 cycles -> mem_ready stays 1, register unchanged, FSM returns to IDLE after stall falls.
